rv_lsu: RTL
===========

# rv_lsu

Load/store unit: the initiator side of the team's 32-bit byte-enabled data memory (`rv_mem`).
- Accepts RV32I load/store requests from the execute stage over a valid/ready handshake.
- Drives word address, byte enables and lane-shifted write data to the memory, and captures its one-cycle registered read data.
- Returns aligned, sign- or zero-extended load results.
- A request that crosses a word boundary is split into two memory beats.

## Interface
Parameters:
- `ALLOW_MISALIGNED`, default 1: 1 = split word-crossing accesses into two beats; 0 = any address not a multiple of the access size returns an error.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted when `req_valid && req_ready`.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: access size and signedness.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data, right-justified.
- `mem_addr`, out, 32: word index, `{2'b0, word}`.
- `mem_wr_en`, out, 1: memory write strobe.
- `mem_wr_data`, out, 32: lane-positioned write data.
- `mem_byte_en`, out, 4: lane enables for both reads and writes. Disabled lanes read back as 0.
- `mem_rd_data`, in, 32: memory read data, valid the cycle after the access cycle.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_rdata`, out, 32: load result; 0 for stores and errors.
- `rsp_err`, out, 1: illegal funct3, or misaligned access with `ALLOW_MISALIGNED`=0.

## Operation
Lane arithmetic:
- Access size S is 1, 2 or 4 bytes; offset o = `req_addr[1:0]`.
- 8-bit lane mask m = ((1<<S)-1) << o.
- Beat 0: word W = `req_addr[31:2]`, `mem_byte_en` = m[3:0].
- Beat 1: word (W+1) mod 2^30, `mem_byte_en` = m[7:4]. It exists only if m[7:4] != 0.
- Store data: 64-bit `req_wdata << 8*o`. Beat 0 takes bits [31:0], beat 1 takes bits [63:32].
- Load data: ({beat1_data, beat0_data} >> 8*o), truncated to S bytes, then extended.
  - Extension is sign for funct3[2]=0 and zero for funct3[2]=1.
  - For a single-beat load, beat1_data = 0.

Illegal funct3 codes:
- Loads: 011, 110, 111.
- Stores: 011, 1xx.

Error request:
- No memory access is made: `mem_wr_en`=0, `mem_byte_en`=0.
- The RESP cycle carries `rsp_err`=1 and `rsp_rdata`=0.

States:
- IDLE
  - `req_ready`=1.
  - Memory outputs are driven combinationally from the request in the accept cycle; this is beat 0.
  - On accept, go to SPLIT if beat 1 exists, else RESP.
  - With no accept: `mem_addr`=0, `mem_byte_en`=0, `mem_wr_en`=0.
- SPLIT
  - `req_ready`=0.
  - Issue beat 1 from latched fields.
  - Latch `mem_rd_data` (beat-0 data) into a holding register.
  - Go to RESP.
- RESP
  - `req_ready`=0, `rsp_valid`=1.
  - Load: `rsp_rdata` is formed from the holding register and/or `mem_rd_data`.
  - Store: `rsp_rdata`=0.
  - Go to IDLE.

## Timing
- Accept at cycle 0:
  - Single-beat request: `rsp_valid` in cycle 1.
  - Split request: beat 1 in cycle 1, `rsp_valid` in cycle 2.
  - `req_ready` returns high the cycle after RESP.
- Store writes take effect at the clock edge that ends each beat's cycle.
- `rsp_rdata`=0 and `rsp_err`=0 whenever `rsp_valid`=0.
- Reset values:
  - State IDLE.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - Holding register 0.
  - While `rst`=1: `req_ready`=0, `mem_wr_en`=0, `mem_byte_en`=0, `mem_addr`=0.
- Reset mid-operation:
  - The pending beat and response are dropped.
  - An already-written beat-0 store is not rolled back.
- Address wrap: LH at 0xFFFFFFFF puts beat 1 at word 0.

## Structure
- `rv_lsu_pkg` holds:
  - the state enum (IDLE/SPLIT/RESP);
  - funct3 constants;
  - a size-decode function (funct3 → S, legal flag).
- Sub-module `rv_lsu_align`, purely combinational, computes:
  - the lane mask;
  - the 64-bit store shift;
  - load merge, shift and extension.
- The FSM and latched request fields live in `rv_lsu`. Registers use the shared DFF macros with reset.

## Test plan
1. SW 0xDEADBEEF at 0x10, then LW at 0x10.
   - Write: `mem_addr`=4, `mem_byte_en`=1111.
   - Load: `rsp_rdata`=0xDEADBEEF in cycle 1.
2. SB 0x000000A5 at 0x13.
   - Write: `mem_addr`=4, `mem_byte_en`=1000, `mem_wr_data`=0xA5000000.
   - LB at 0x13 returns 0xFFFFFFA5; LBU at 0x13 returns 0x000000A5.
3. Memory word3=0x44332211, word4=0x88776655; LW at 0x0E.
   - Beat 0: word 3, `mem_byte_en`=1100. Beat 1: word 4, `mem_byte_en`=0011.
   - Cycle 2: `rsp_rdata`=0x66554433.
4. SH 0x0000BEEF at 0x0F.
   - Beat 0: word 3, `mem_byte_en`=1000, `mem_wr_data`=0xEF000000.
   - Beat 1: word 4, `mem_byte_en`=0001, `mem_wr_data`=0x000000BE.
5. Error cases, all with no memory access:
   - Load with funct3=011: cycle 1 `rsp_err`=1, `rsp_rdata`=0.
   - `ALLOW_MISALIGNED`=0, LH at 0x01: `rsp_err`=1.
6. Reset and wrap:
   - `rst` high during SPLIT of LW at 0x0E: no beat-1 access, no `rsp_valid`, `req_ready`=1 in the first cycle after `rst` falls.
   - LH at 0xFFFFFFFF: beat 1 at word 0 with `mem_byte_en`=0001.

Source files
------------

// File: rtl/rv_lsu_pkg.sv
// Shared types and decode helpers for the rv_lsu load/store unit.
package rv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPLIT,
        ST_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       legal;
        logic [1:0] size_log2;
        logic       is_unsigned;
    } size_dec_t;

    // Unsigned variants exist only for loads; everything else is illegal.
    function automatic size_dec_t decode_size(input logic we, input logic [2:0] funct3);
        size_dec_t d;
        d.size_log2   = funct3[1:0];
        d.is_unsigned = funct3[2];
        case (funct3)
            F3_B, F3_H, F3_W: d.legal = 1'b1;
            F3_BU, F3_HU:     d.legal = ~we;
            default:          d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Request/response handshake between the execute stage (master) and the LSU (slave).
interface rv_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/rv_lsu_align.sv
// Combinational lane arithmetic: byte-lane mask, store data shift, load merge and extension.
module rv_lsu_align (
    input  logic [1:0]  size_log2,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] beat0_data,
    input  logic [31:0] beat1_data,
    output logic [7:0]  lane_mask,
    output logic [63:0] wdata_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  base_mask;
    logic [4:0]  shamt;
    logic [31:0] merged;

    always_comb begin
        case (size_log2)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        shamt       = {offset, 3'b000};
        lane_mask   = base_mask << offset;
        wdata_lanes = {32'h0, wdata} << shamt;
        merged      = 32'({beat1_data, beat0_data} >> shamt);
        case (size_log2)
            2'd0:    load_data = {{24{~is_unsigned & merged[7]}}, merged[7:0]};
            2'd1:    load_data = {{16{~is_unsigned & merged[15]}}, merged[15:0]};
            default: load_data = merged;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// RV32I load/store unit: drives the byte-enabled data memory, splitting word-crossing accesses.
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int unsigned ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    rv_lsu_if.slave     bus,
    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rd_data
);

    state_t      state, state_next;
    size_dec_t   dec;
    logic        ready;
    logic        accept;
    logic        misaligned;
    logic        req_err;
    logic        has_beat1;

    logic        l_we;
    logic [1:0]  l_size;
    logic        l_unsigned;
    logic [1:0]  l_offset;
    logic [29:0] l_word;
    logic [31:0] l_wdata;
    logic        l_err;
    logic        l_split;
    logic [31:0] hold;

    logic        in_idle;
    logic [1:0]  al_size;
    logic [1:0]  al_offset;
    logic        al_unsigned;
    logic [31:0] al_wdata;
    logic [31:0] al_beat0;
    logic [31:0] al_beat1;
    logic [7:0]  lane_mask;
    logic [63:0] wdata_lanes;
    logic [31:0] load_data;

    assign dec        = decode_size(bus.req_we, bus.req_funct3);
    assign ready      = (state == ST_IDLE) && !rst;
    assign accept     = bus.req_valid && ready;
    assign misaligned = (dec.size_log2 == 2'd1 && bus.req_addr[0]) ||
                        (dec.size_log2 == 2'd2 && bus.req_addr[1:0] != 2'b00);
    assign req_err    = !dec.legal || (ALLOW_MISALIGNED == 0 && misaligned);
    assign has_beat1  = |lane_mask[7:4];

    // One aligner serves both phases: live request fields in IDLE, latched fields afterwards.
    assign in_idle     = (state == ST_IDLE);
    assign al_size     = in_idle ? dec.size_log2     : l_size;
    assign al_offset   = in_idle ? bus.req_addr[1:0] : l_offset;
    assign al_unsigned = in_idle ? dec.is_unsigned   : l_unsigned;
    assign al_wdata    = in_idle ? bus.req_wdata     : l_wdata;
    assign al_beat0    = l_split ? hold        : mem_rd_data;
    assign al_beat1    = l_split ? mem_rd_data : 32'h0;

    rv_lsu_align u_align (
        .size_log2   (al_size),
        .offset      (al_offset),
        .is_unsigned (al_unsigned),
        .wdata       (al_wdata),
        .beat0_data  (al_beat0),
        .beat1_data  (al_beat1),
        .lane_mask   (lane_mask),
        .wdata_lanes (wdata_lanes),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = (req_err || !has_beat1) ? ST_RESP : ST_SPLIT;
            end
            ST_SPLIT: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = 32'h0;
        mem_addr      = 32'h0;
        mem_wr_en     = 1'b0;
        mem_wr_data   = 32'h0;
        mem_byte_en   = 4'h0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid && !req_err) begin
                        mem_addr    = {2'b00, bus.req_addr[31:2]};
                        mem_byte_en = lane_mask[3:0];
                        mem_wr_en   = bus.req_we;
                        mem_wr_data = bus.req_we ? wdata_lanes[31:0] : 32'h0;
                    end
                end
                ST_SPLIT: begin
                    mem_addr    = {2'b00, l_word + 30'd1};
                    mem_byte_en = lane_mask[7:4];
                    mem_wr_en   = l_we;
                    mem_wr_data = l_we ? wdata_lanes[63:32] : 32'h0;
                end
                ST_RESP: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_err   = l_err;
                    bus.rsp_rdata = (l_we || l_err) ? 32'h0 : load_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_we       <= 1'b0;
            l_size     <= '0;
            l_unsigned <= 1'b0;
            l_offset   <= '0;
            l_word     <= '0;
            l_wdata    <= '0;
            l_err      <= 1'b0;
            l_split    <= 1'b0;
        end else if (accept) begin
            l_we       <= bus.req_we;
            l_size     <= dec.size_log2;
            l_unsigned <= dec.is_unsigned;
            l_offset   <= bus.req_addr[1:0];
            l_word     <= bus.req_addr[31:2];
            l_wdata    <= bus.req_wdata;
            l_err      <= req_err;
            l_split    <= !req_err && has_beat1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                    hold <= '0;
        else if (state == ST_SPLIT) hold <= mem_rd_data;
    end

endmodule
